plane_move_ctrl: RTL and testbench

PLANE_MOVE_CTRL -- requirements
Module: plane_move_ctrl

---
 rtl/plane_move_ctrl.sv | 159 +++++++++++++++
 tb/tb_plane_move_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/plane_move_ctrl.sv
// plane_move_ctrl: moves the player plane by STEP pixels on button presses, with
// press-and-hold auto-repeat (first repeat after HOLD_CYCLES, then every REPEAT_CYCLES).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   move_en_i  a single direction button is pressed
//   direct_i   direction code (UP/DOWN/LEFT/RIGHT), valid only with move_en_i
//   freeze_i   pause / game over, blocks all movement
//   pos_x_o    registered plane X position
//   pos_y_o    registered plane Y position
//   moved_o    registered one-cycle pulse on every edge where the position changes
module plane_move_ctrl #(
  parameter int unsigned STEP          = 4,
  parameter int unsigned HOLD_CYCLES   = 5_000_000,
  parameter int unsigned REPEAT_CYCLES = 1_000_000,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 620,
  parameter int unsigned Y_MIN         = 0,
  parameter int unsigned Y_MAX         = 460,
  parameter int unsigned X_INIT        = 300,
  parameter int unsigned Y_INIT        = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_en_i,
  input  logic [1:0] direct_i,
  input  logic       freeze_i,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic       moved_o
);

  // Direction encoding shared with the rest of the game logic.
  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  localparam int unsigned MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                    : REPEAT_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);

  // 11-bit arithmetic so pos + STEP cannot wrap before the clamp compare.
  localparam logic [10:0] StepW = 11'(STEP);
  localparam logic [10:0] XMinW = 11'(X_MIN);
  localparam logic [10:0] XMaxW = 11'(X_MAX);
  localparam logic [10:0] YMinW = 11'(Y_MIN);
  localparam logic [10:0] YMaxW = 11'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dir_q, dir_d;
  logic [9:0]      pos_x_q, pos_x_d;
  logic [9:0]      pos_y_q, pos_y_d;
  logic            moved_q, moved_d;
  logic            step_req;
  logic [10:0]     x_w, y_w;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= DirDown;
      pos_x_q <= 10'(X_INIT);
      pos_y_q <= 10'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      moved_q <= moved_d;
    end
  end

  // Next-state: press/hold/repeat timing and step requests.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_req = 1'b0;
    if (freeze_i) begin
      // Returning to idle makes a still-held button count as a new press later.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (move_en_i) begin
            step_req = 1'b1;
            dir_d    = direct_i;
            cnt_d    = '0;
            state_d  = StHold;
          end
        end
        StHold, StRepeat: begin
          if (!move_en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (direct_i != dir_q) begin
            step_req = 1'b1;
            dir_d    = direct_i;
            cnt_d    = '0;
            state_d  = StHold;
          end else if (state_q == StHold) begin
            if (cnt_q == HoldLast) begin
              step_req = 1'b1;
              cnt_d    = '0;
              state_d  = StRepeat;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            if (cnt_q == RepeatLast) begin
              step_req = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: clamped position update; a clamped no-op step raises no pulse.
  always_comb begin
    x_w     = {1'b0, pos_x_q};
    y_w     = {1'b0, pos_y_q};
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (step_req) begin
      case (direct_i)
        DirUp:    pos_y_d = 10'((y_w < YMinW + StepW) ? YMinW : y_w - StepW);
        DirDown:  pos_y_d = 10'((y_w + StepW > YMaxW) ? YMaxW : y_w + StepW);
        DirLeft:  pos_x_d = 10'((x_w < XMinW + StepW) ? XMinW : x_w - StepW);
        default:  pos_x_d = 10'((x_w + StepW > XMaxW) ? XMaxW : x_w + StepW);
      endcase
    end
    moved_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
  end

  assign pos_x_o = pos_x_q;
  assign pos_y_o = pos_y_q;
  assign moved_o = moved_q;

endmodule

// File: tb/tb_plane_move_ctrl.sv
module tb_plane_move_ctrl;

  localparam int unsigned Step = 4;
  localparam int unsigned Hold = 4;
  localparam int unsigned Rep  = 2;
  localparam logic [1:0] DUp = 2'd0, DDown = 2'd1, DLeft = 2'd2, DRight = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_en = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       freeze = 1'b0;
  logic [9:0] px, py;
  logic       moved;

  always #5 clk = ~clk;

  plane_move_ctrl #(
    .STEP         (Step),
    .HOLD_CYCLES  (Hold),
    .REPEAT_CYCLES(Rep)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .move_en_i(move_en),
    .direct_i (dir),
    .freeze_i (freeze),
    .pos_x_o  (px),
    .pos_y_o  (py),
    .moved_o  (moved)
  );

  typedef struct {int x; int y; int m;} exp_t;
  exp_t sbq[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  pulse_cnt = 0;
  bit  armed = 0;
  bit  done  = 0;

  // Reference model: time since press, not an FSM.
  int       mx = 300, my = 400;
  bit       act = 0;
  logic [1:0] ldir = DDown;
  int       t = 0;

  function automatic void check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  function automatic void model(bit r, bit en, logic [1:0] d, bit f);
    exp_t e;
    bit   st = 0;
    int   ox = mx, oy = my;
    if (r) begin
      mx = 300; my = 400; act = 0;
      ox = mx; oy = my;
    end else begin
      if (f || !en) act = 0;
      else if (!act || d != ldir) begin
        act = 1; ldir = d; t = 0; st = 1;
      end else begin
        t++;
        st = (t == Hold) || (t > Hold && (t - Hold) % Rep == 0);
      end
      if (st) begin
        case (d)
          DUp:    my = (my - 4 < 0)   ? 0   : my - 4;
          DDown:  my = (my + 4 > 460) ? 460 : my + 4;
          DLeft:  mx = (mx - 4 < 0)   ? 0   : mx - 4;
          default: mx = (mx + 4 > 620) ? 620 : mx + 4;
        endcase
      end
    end
    e.x = mx; e.y = my;
    e.m = (mx != ox || my != oy) ? 1 : 0;
    sbq.push_back(e);
  endfunction

  task automatic drive(bit r, bit en, logic [1:0] d, bit f);
    @(negedge clk);
    rst = r; move_en = en; dir = d; freeze = f;
    model(r, en, d, f);
    armed = 1;
  endtask

  // Sample state right after the edge that consumed the last driven inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1, 0, DUp, 0);
    drive(1, 0, DUp, 0);
  endtask

  // Monitor: outputs are registered every cycle, so one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_pos_x", int'(px), e.x);
        check("sb_pos_y", int'(py), e.y);
        check("sb_moved", int'(moved), e.m);
        if (moved) pulse_cnt++;
      end else if (armed && !done) begin
        check("sb_underflow", 1, 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [1:0] d;
    // Tap RIGHT once
    do_reset();
    settle();
    check("reset_x", int'(px), 300);
    check("reset_y", int'(py), 400);
    check("reset_moved", int'(moved), 0);
    p0 = pulse_cnt;
    drive(0, 1, DRight, 0);
    drive(0, 0, DRight, 0);
    drive(0, 0, DLeft, 0);
    settle();
    check("tap_x", int'(px), 304);
    check("tap_pulses", pulse_cnt - p0, 1);

    // Hold LEFT 10 edges
    do_reset();
    settle();
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) drive(0, 1, DLeft, 0);
    settle();
    check("holdleft_x", int'(px), 284);
    check("holdleft_pulses", pulse_cnt - p0, 4);
    drive(0, 0, DLeft, 0);

    // Clamp at right edge
    do_reset();
    for (int i = 0; i < 79; i++) begin
      drive(0, 1, DRight, 0);
      drive(0, 0, DRight, 0);
    end
    settle();
    check("taps79_x", int'(px), 616);
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) drive(0, 1, DRight, 0);
    settle();
    check("clamp_x", int'(px), 620);
    check("clamp_pulses", pulse_cnt - p0, 1);
    drive(0, 0, DRight, 0);

    // Direction switch UP -> DOWN
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, DUp, 0);
    settle();
    check("up5_y", int'(py), 392);
    drive(0, 1, DDown, 0);
    settle();
    check("switch_y", int'(py), 396);
    for (int i = 0; i < 3; i++) drive(0, 1, DDown, 0);
    settle();
    check("switch_wait_y", int'(py), 396);
    drive(0, 1, DDown, 0);
    settle();
    check("switch_next_y", int'(py), 400);
    drive(0, 0, DDown, 0);

    // Reset mid-REPEAT with button held
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 1, DRight, 0);
    drive(1, 1, DRight, 0);
    settle();
    check("rst_mid_x", int'(px), 300);
    check("rst_mid_moved", int'(moved), 0);
    drive(0, 1, DRight, 0);
    settle();
    check("post_rst_x", int'(px), 304);
    drive(0, 0, DRight, 0);

    // Freeze
    do_reset();
    settle();
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) drive(0, 1, DDown, 1);
    settle();
    check("freeze_y", int'(py), 400);
    check("freeze_pulses", pulse_cnt - p0, 0);
    drive(0, 1, DDown, 0);
    settle();
    check("unfreeze_y", int'(py), 404);

    // Random segments of held directions, with sparse reset/freeze/release
    for (int s = 0; s < 50; s++) begin
      int len;
      d   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 120);
      for (int i = 0; i < len; i++) begin
        bit r, f, en;
        r  = ($urandom_range(0, 299) == 0);
        f  = ($urandom_range(0, 39) == 0);
        en = ($urandom_range(0, 24) != 0);
        if ($urandom_range(0, 29) == 0) d = 2'($urandom_range(0, 3));
        drive(r, en, en ? d : 2'($urandom_range(0, 3)), f);
      end
    end

    settle();
    #3;
    done = 1;
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
